// File: rtl/ysyx_25030093_pkg.sv
// Types shared by fetch, the fetch/decode queue and decode.
package ysyx_25030093_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_25030093_ifu_idu_queue_if.sv
// Valid/ready channel carrying one fetch packet; master drives valid and pkt.
interface ysyx_25030093_ifu_idu_queue_if;
  import ysyx_25030093_pkg::*;

  logic       valid;
  logic       ready;
  fetch_pkt_t pkt;

  modport master (output valid, output pkt, input ready);
  modport slave  (input valid, input pkt, output ready);

endinterface

// File: rtl/ysyx_25030093_queue_ram.sv
// Queue storage: DEPTH packet registers, one write port, one asynchronous read port.
module ysyx_25030093_queue_ram
  import ysyx_25030093_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pkt_t    wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pkt_t    rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25030093_ifu_idu_queue.sv
// In-order fetch->decode packet queue with single-cycle flush on redirect.
module ysyx_25030093_ifu_idu_queue
  import ysyx_25030093_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_25030093_ifu_idu_queue_if.slave  in_if,
  ysyx_25030093_ifu_idu_queue_if.master out_if,
  input  logic                          flush,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic       in_ready;
  logic       out_valid;
  logic       push;
  logic       pop;
  fetch_pkt_t head_pkt;

  // Handshake outputs depend only on registered occupancy, never on out_if.ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_if.valid & in_ready;
  assign pop       = out_valid & out_if.ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flushed packet must not land in storage even though it is discarded by the pointers.
  ysyx_25030093_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (in_if.pkt),
    .raddr (rd_ptr_q),
    .rdata (head_pkt)
  );

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.pkt   = out_valid ? head_pkt : '0;
  assign count        = count_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu_idu_queue.sv
// Scoreboard bench for the fetch/decode queue.
module tb_ysyx_25030093_ifu_idu_queue;
  import ysyx_25030093_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;

  ysyx_25030093_ifu_idu_queue_if in_if ();
  ysyx_25030093_ifu_idu_queue_if out_if ();

  ysyx_25030093_ifu_idu_queue #(.DEPTH(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (in_if),
    .out_if (out_if),
    .flush  (flush),
    .count  (count)
  );

  always #5 clk = ~clk;

  fetch_pkt_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: updated from bench-driven inputs only.
  bit m_push, m_pop;
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      m_pop  = (sb.size() != 0) && out_if.ready;
      m_push = in_if.valid && (sb.size() < 4);
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(in_if.pkt);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".count"}, 64'(count), 64'(sb.size()));
    check_eq({tag, ".out_valid"}, 64'(out_if.valid), 64'(sb.size() != 0));
    check_eq({tag, ".in_ready"}, 64'(in_if.ready), 64'(sb.size() != 4));
    check_eq({tag, ".out_pc"}, 64'(out_if.pkt.pc), (sb.size() != 0) ? 64'(sb[0].pc) : 64'd0);
    check_eq({tag, ".out_inst"}, 64'(out_if.pkt.inst), (sb.size() != 0) ? 64'(sb[0].inst) : 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_if.valid    = v;
    in_if.pkt.pc   = pc;
    in_if.pkt.inst = inst;
  endtask

  initial begin
    drive_in(1'b0, 32'd0, 32'd0);
    out_if.ready = 1'b0;

    // reset
    step();
    step();
    check_state("rst_low");
    rst_n = 1'b1;
    step();
    check_state("reset");

    // fill to full, then a rejected fifth push
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0000_0013);
      step();
      check_state("fill");
    end
    drive_in(1'b1, 32'h8000_0010, 32'h0000_0013);
    step();
    check_state("fifth");
    check_eq("fifth.count", 64'(count), 64'd4);
    check_eq("fifth.in_ready", 64'(in_if.ready), 64'd0);
    drive_in(1'b0, 32'd0, 32'd0);

    // drain order
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain.pc", 64'(out_if.pkt.pc), 64'h8000_0000 + 64'(4 * i));
      step();
      check_state("drain");
    end
    check_eq("drain.empty", 64'(out_if.valid), 64'd0);

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, 32'h0000_0100 + 32'(4 * i), 32'(i));
      step();
      check_state("stream");
      check_eq("stream.pc", 64'(out_if.pkt.pc), 64'h100 + 64'(4 * i));
      check_eq("stream.count", 64'(count), 64'd1);
    end
    drive_in(1'b0, 32'd0, 32'd0);
    step();
    check_state("stream_end");

    // flush priority over push and pop
    out_if.ready = 1'b0;
    drive_in(1'b1, 32'h0000_0200, 32'h11);
    step();
    drive_in(1'b1, 32'h0000_0204, 32'h22);
    step();
    check_eq("pre_flush.count", 64'(count), 64'd2);
    flush = 1'b1;
    out_if.ready = 1'b1;
    drive_in(1'b1, 32'h0000_BAD0, 32'h33);
    step();
    flush = 1'b0;
    drive_in(1'b0, 32'd0, 32'd0);
    check_state("flush");
    check_eq("flush.count", 64'(count), 64'd0);
    check_eq("flush.out_valid", 64'(out_if.valid), 64'd0);
    check_eq("flush.in_ready", 64'(in_if.ready), 64'd1);
    step();
    check_state("post_flush");

    // stall hold
    out_if.ready = 1'b0;
    drive_in(1'b1, 32'h0000_0300, 32'h0000_ABCD);
    step();
    drive_in(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_state("stall");
      check_eq("stall.pc", 64'(out_if.pkt.pc), 64'h300);
      check_eq("stall.inst", 64'(out_if.pkt.inst), 64'hABCD);
      check_eq("stall.count", 64'(count), 64'd1);
    end

    // asynchronous reset mid-cycle with count=3
    drive_in(1'b1, 32'h0000_0304, 32'h44);
    step();
    drive_in(1'b1, 32'h0000_0308, 32'h55);
    step();
    drive_in(1'b0, 32'd0, 32'd0);
    check_eq("pre_rst.count", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("async_rst.count", 64'(count), 64'd0);
    check_eq("async_rst.out_valid", 64'(out_if.valid), 64'd0);
    check_eq("async_rst.in_ready", 64'(in_if.ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check_state("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
